// File: rtl/mem_dcache_ctrl.sv
// MEM-stage data-cache access controller.
// Issues one load/store per instruction on a valid/ready D-cache port and
// waits for load data. Returned data is aligned and extended, then held until
// MEM2 accepts it. The pipeline stalls while the access is outstanding.
module mem_dcache_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_Flush,
  input  logic        MEM2_Wr,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_OutB,
  input  logic        MEM_ReadEn,
  input  logic [1:0]  MEM_LoadSize,
  input  logic        MEM_LoadSign,
  input  logic [3:0]  MEM_DCache_Wen,
  input  logic        MEM_ExceptValid,
  output logic        req_valid,
  output logic        req_wr,
  output logic [31:0] req_addr,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_wdata,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  output logic [31:0] MEM_LoadData,
  output logic        MEM_Stall,
  output logic        MEM_DCacheTimeout
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  localparam logic [9:0] TIMEOUT_VAL = 10'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic        acc;
  logic        xfer;
  logic        capture;
  logic [9:0]  wait_cnt;
  logic [9:0]  wait_cnt_inc;
  logic [31:0] load_ext;

  // Select the addressed byte/half of the returned word and extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = word >> {off, 3'b000};
    half    = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    return {{24{sgn & shifted[7]}}, shifted[7:0]};
      2'd1:    return {{16{sgn & half[15]}}, half};
      default: return word;
    endcase
  endfunction

  assign acc          = (MEM_ReadEn | (MEM_DCache_Wen != 4'b0000)) & ~MEM_ExceptValid;
  assign req_wr       = (MEM_DCache_Wen != 4'b0000);
  assign req_addr     = {MEM_ALUOut[31:2], 2'b00};
  assign req_wstrb    = MEM_DCache_Wen;
  assign req_wdata    = MEM_OutB << {MEM_ALUOut[1:0], 3'b000};
  assign load_ext     = extend_load(resp_rdata, MEM_ALUOut[1:0], MEM_LoadSize, MEM_LoadSign);
  assign xfer         = req_valid & req_ready;
  assign capture      = (state == WAIT) & resp_valid & ~MEM_Flush;
  assign wait_cnt_inc = (wait_cnt == 10'h3FF) ? wait_cnt : wait_cnt + 10'd1;

  // Request and stall outputs; both are forced low while reset is held.
  always_comb begin
    req_valid = ~rst & ~MEM_Flush & (((state == IDLE) & acc) | (state == REQ));
    MEM_Stall = ~rst & (((state == IDLE) & acc) | (state == REQ) |
                        (state == WAIT) | (state == DRAIN));
  end

  // Next-state logic; flush overrides every other event except in DRAIN.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: begin
        if (!MEM_Flush && acc) begin
          if (xfer) state_next = req_wr ? DONE : WAIT;
          else      state_next = REQ;
        end
      end
      REQ: begin
        if (MEM_Flush) state_next = IDLE;
        else if (xfer) state_next = req_wr ? DONE : WAIT;
      end
      WAIT: begin
        if (MEM_Flush)       state_next = resp_valid ? IDLE : DRAIN;
        else if (resp_valid) state_next = DONE;
      end
      DONE: begin
        if (MEM_Flush || MEM2_Wr) state_next = IDLE;
      end
      DRAIN: begin
        if (resp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, load-data capture, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      MEM_LoadData      <= 32'h0;
      MEM_DCacheTimeout <= 1'b0;
      wait_cnt          <= 10'h0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      state <= state_next;
      if (capture) MEM_LoadData <= load_ext;
      if (state != WAIT && state_next == WAIT) begin
        wait_cnt <= 10'h0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt_inc;
        if (wait_cnt_inc == TIMEOUT_VAL) MEM_DCacheTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_dcache_ctrl.md
Name: mem_dcache_ctrl

Overview:
- MEM-stage data-cache access controller. It sits directly downstream of the EXE/MEM pipeline register and consumes that register's MEM_* outputs: address from ALUOut, store data from OutB, load type, byte write enables and exception state.
- It issues one load or store request per instruction on a valid/ready D-cache port and waits for load data.
- It aligns and sign/zero-extends the returned load data, holds the result until the MEM2 stage accepts it, and stalls the pipeline while the access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 1023: WAIT cycles after which the sticky timeout flag sets. Range 1..1023.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- MEM_Flush  in  1  kill the instruction currently in MEM
- MEM2_Wr  in  1  MEM2 register latches this cycle (downstream accept)
- MEM_ALUOut  in  32  effective address
- MEM_OutB  in  32  store data, unaligned (register value)
- MEM_ReadEn  in  1  instruction is a load
- MEM_LoadSize  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word
- MEM_LoadSign  in  1  1 = sign-extend, 0 = zero-extend
- MEM_DCache_Wen  in  4  byte write enables; nonzero = store
- MEM_ExceptValid  in  1  exception pending; suppresses the access
- req_valid  out  1  D-cache request valid
- req_wr  out  1  1 = store
- req_addr  out  32  {MEM_ALUOut[31:2], 2'b00}
- req_wstrb  out  4  equals MEM_DCache_Wen
- req_wdata  out  32  MEM_OutB shifted left by 8*MEM_ALUOut[1:0]
- req_ready  in  1  D-cache accepts request
- resp_valid  in  1  load data valid
- resp_rdata  in  32  aligned word
- MEM_LoadData  out  32  extended load result, registered
- MEM_Stall  out  1  hold IF..MEM
- MEM_DCacheTimeout  out  1  sticky, set when a load waits TIMEOUT_CYCLES

Behaviour:
- Access condition: acc = (MEM_ReadEn | (MEM_DCache_Wen != 0)) & ~MEM_ExceptValid.
- States: IDLE, REQ, WAIT, DONE, DRAIN. On reset: state = IDLE, MEM_LoadData = 0, MEM_DCacheTimeout = 0, wait counter = 0. While rst is high, req_valid and MEM_Stall are 0.
- Request output: req_valid = ((IDLE & acc) | REQ) & ~MEM_Flush. req_wr, req_addr, req_wstrb and req_wdata are combinational from the MEM_* inputs, which stay stable while MEM_Stall holds MEM_Reg.
- Handshake: a transfer occurs when req_valid & req_ready.
  - Load transfer goes to WAIT.
  - Store transfer goes to DONE; stores receive no response.
  - No transfer (IDLE & acc): go to REQ.
  - Once valid is raised, req_valid stays high until ready or flush.
- WAIT: on resp_valid, capture the extended data into MEM_LoadData and go to DONE. This gives 1-cycle latency from resp_valid to MEM_LoadData.
- Load extension uses off = MEM_ALUOut[1:0]:
  - Byte: takes resp_rdata[8*off+7 : 8*off].
  - Half: takes resp_rdata[16*off[1]+15 : 16*off[1]]; off[0] is ignored because misalignment is excepted upstream.
  - Extended to 32 bits per MEM_LoadSign.
- DONE: on MEM2_Wr go to IDLE; otherwise hold. The access is never re-issued.
- MEM_Stall = (IDLE & acc) | REQ | WAIT | DRAIN. It is low in DONE and in IDLE with no access.
- Minimum stall:
  - Store accepted in its first cycle: 1 cycle.
  - Load with resp_valid the cycle after acceptance: 2 cycles.
- Flush, which has priority over every other event:
  - IDLE or REQ: request suppressed, go to IDLE.
  - WAIT with resp_valid in the same cycle: response discarded, go to IDLE.
  - WAIT otherwise: go to DRAIN. DRAIN stays until resp_valid, discards the data and returns to IDLE. Flush in DRAIN is ignored.
  - DONE: go to IDLE; MEM_LoadData is not cleared.
- resp_valid outside WAIT/DRAIN is ignored; the bench flags it as a protocol error.
- Counter: 10-bit. It clears on entry to WAIT, increments each cycle in WAIT and saturates at 1023. MEM_DCacheTimeout sets when the counter equals TIMEOUT_CYCLES and clears only on rst.
- Reset asserted mid-access: immediate return to IDLE with the reset values above. The cache side is reset by the same rst.

Test Plan:
- Word load at 0x80001004, ready=1, resp_valid one cycle later with 0xDEADBEEF -> MEM_Stall high 2 cycles; MEM_LoadData = 0xDEADBEEF in DONE; IDLE after MEM2_Wr.
- Signed byte load at addr 0x...03, rdata 0x80FF1234 -> 0xFFFFFF80. Unsigned half at 0x...02 -> 0x000080FF.
- Store byte, Wen = 4'b0100, OutB = 0x000000AB, addr 0x...02, req_ready low 3 cycles -> req_valid high 4 cycles; req_wdata = 0x00AB0000, req_addr aligned; stall released the cycle after the handshake.
- Load accepted, MEM_Flush in WAIT, resp_valid 2 cycles later -> DRAIN; MEM_LoadData unchanged; MEM_Stall high until return to IDLE.
- Load with MEM_ExceptValid = 1 -> req_valid never asserted, MEM_Stall 0. Flush in the same cycle as req_ready -> no handshake.
- TIMEOUT_CYCLES = 8, no response -> MEM_DCacheTimeout rises after 8 WAIT cycles; it stays set after the response arrives and clears only on rst.
